axi4_lite_mps_master: RTL and testbench



---
 rtl/axi4_lite_mps_master.sv | 199 +++++++++++++++++++
 tb/tb_axi4_lite_mps_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_mps_master.sv
// AXI4-Lite single-transaction initiator for the MPS control logic.
// One request at a time: AW/W/B for writes, AR/R for reads, one response pulse.
// Optional watchdog enabled by defining MPS_AXI_MASTER_TIMEOUT_EN; a hung slave
// then produces a SLVERR response with o_timeout instead of a stuck FSM.
module axi4_lite_mps_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              i_req_valid,
    output logic                              o_req_ready,
    input  logic                              i_req_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_req_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   i_req_wstrb,
    output logic                              o_rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic [1:0]                        o_rsp_resp,
    output logic                              o_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RESP} state_t;

    if (C_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("C_TIMEOUT_CYCLES must be at least 2");
    end

    state_t                         state_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]  wdata_q;
    logic [SW-1:0]                  wstrb_q;
    logic                           awvalid_q, wvalid_q, aw_done_q, w_done_q;
    logic                           bready_q, arvalid_q, rready_q;
    logic                           rsp_valid_q, timeout_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]  rdata_q;
    logic [1:0]                     resp_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_done_d, w_done_d, expire;

    assign aw_hs     = awvalid_q & M_AXI_AWREADY;
    assign w_hs      = wvalid_q  & M_AXI_WREADY;
    assign b_hs      = bready_q  & M_AXI_BVALID;
    assign ar_hs     = arvalid_q & M_AXI_ARREADY;
    assign r_hs      = rready_q  & M_AXI_RVALID;
    // Done flags include this cycle's handshake so WR_RESP is entered on the handshake edge
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q  | w_hs;

`ifdef MPS_AXI_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          busy, any_hs;

    assign busy   = (state_q == WR) || (state_q == WR_RESP) ||
                    (state_q == RD) || (state_q == RD_DATA);
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    // Expire on the edge where the counter reaches the limit; a handshake on that edge wins
    assign expire = busy & ~any_hs & (cnt_q == CNT_LAST);

    // Watchdog: restarts on accept or any handshake, counts while waiting on the bus
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET)
            cnt_q <= '0;
        else if ((state_q == IDLE && i_req_valid) || any_hs)
            cnt_q <= '0;
        else if (busy)
            cnt_q <= cnt_q + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    // Transaction FSM with registered AXI handshake outputs and response
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= 2'b00;
        end else begin
            rsp_valid_q <= 1'b0;
            if (expire) begin
                // Hung slave: abandon every channel and report SLVERR
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                rdata_q     <= '0;
                resp_q      <= 2'b10;
                timeout_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
            end else begin
                case (state_q)
                    IDLE: if (i_req_valid) begin
                        addr_q  <= i_req_addr;
                        wdata_q <= i_req_wdata;
                        wstrb_q <= i_req_wstrb;
                        if (i_req_wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD;
                        end
                    end
                    WR: begin
                        if (aw_hs) awvalid_q <= 1'b0;
                        if (w_hs)  wvalid_q  <= 1'b0;
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                        if (aw_done_d && w_done_d) begin
                            bready_q <= 1'b1;
                            state_q  <= WR_RESP;
                        end
                    end
                    WR_RESP: if (b_hs) begin
                        bready_q    <= 1'b0;
                        resp_q      <= M_AXI_BRESP;
                        rdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                    RD: if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                    RD_DATA: if (r_hs) begin
                        rready_q    <= 1'b0;
                        rdata_q     <= M_AXI_RDATA;
                        resp_q      <= M_AXI_RRESP;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                    RESP: begin
                        timeout_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_req_ready   = (state_q == IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_resp    = resp_q;
    assign o_timeout     = timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_mps_master.sv
// Bench for axi4_lite_mps_master: vector table of single transactions against a
// delay-programmable register slave, plus hand sequences for channel skew,
// mid-transaction reset and (with MPS_AXI_MASTER_TIMEOUT_EN) the watchdog.
module tb_axi4_lite_mps_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, tmo;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [5:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi4_lite_mps_master #(.C_TIMEOUT_CYCLES(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
        .o_timeout(tmo),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave knobs: wait cycles per channel, response codes, read-data override, AR hang
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  s_bresp, s_rresp;
    bit          hang_ar, rov_en;
    logic [31:0] rov;

    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_got, w_got, ar_got;
    logic [5:0]  aw_a, ar_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    logic [31:0] mem [16];

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid  && (w_cnt  >= w_dly);
    assign arready = arvalid && !hang_ar && (ar_cnt >= ar_dly);

    // Register-file slave with programmable wait states
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; ar_got <= 0;
            bvalid <= 0; rvalid <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1; aw_a <= awaddr; end
            if (wvalid && wready) begin w_got <= 1; w_d <= wdata; w_s <= wstrb; end
            if (bvalid && bready) bvalid <= 0;
            else if (aw_got && w_got && !bvalid) begin
                if (b_cnt >= b_dly) begin
                    bvalid <= 1; bresp <= s_bresp; aw_got <= 0; w_got <= 0; b_cnt <= 0;
                    for (int i = 0; i < 4; i++)
                        if (w_s[i]) mem[aw_a[5:2]][8*i +: 8] <= w_d[8*i +: 8];
                end else b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin ar_got <= 1; ar_a <= araddr; end
            if (rvalid && rready) rvalid <= 0;
            else if (ar_got && !rvalid) begin
                if (r_cnt >= r_dly) begin
                    rvalid <= 1; rresp <= s_rresp; ar_got <= 0; r_cnt <= 0;
                    rdata <= rov_en ? rov : mem[ar_a[5:2]];
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    int checks = 0, failures = 0, pulses = 0, exp_pulses = 0;

    // Response pulse counter, sampled mid-cycle
    always @(negedge clk) if (rsp_valid) pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered at a negedge; leaves at the negedge after the accept edge
    task automatic issue(input bit wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    endtask

    // Count clock edges until the response pulse is visible (bounded)
    task automatic wait_rsp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
        exp_pulses++;
    endtask

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          awd, wd, bd, ard, rd;
        logic [1:0]  sresp;
        bit          roven;
        logic [31:0] rov;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        aw_dly = v.awd; w_dly = v.wd; b_dly = v.bd; ar_dly = v.ard; r_dly = v.rd;
        s_bresp = v.sresp; s_rresp = v.sresp; rov_en = v.roven; rov = v.rov;
        issue(v.wr, v.addr, v.wdata, v.wstrb);
        wait_rsp(n);
        chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_resp", idx), 32'(rsp_resp), 32'(v.exp_resp));
        chk($sformatf("v%0d_timeout", idx), 32'(tmo), 32'd0);
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.exp_lat));
        @(negedge clk);
        chk($sformatf("v%0d_pulse_width", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_ready_after", idx), 32'(req_ready), 32'd1);
    endtask

    vec_t vecs[12];

    initial begin
        int n, p0;
        // wr addr    wdata         strb  aw w  b  ar r  resp ov ovdata        exp_rdata     resp lat
        vecs[0]  = '{1, 6'h08, 32'h00000001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        32'h00000000, 2'b00, 3};
        vecs[1]  = '{0, 6'h2C, 32'h0,        4'h0, 0, 0, 0, 0, 2, 2'b00, 1, 32'h12345678, 32'h12345678, 2'b00, 5};
        vecs[2]  = '{1, 6'h10, 32'hA5A5A5A5, 4'hF, 0, 3, 0, 0, 0, 2'b00, 0, 32'h0,        32'h00000000, 2'b00, 6};
        vecs[3]  = '{1, 6'h04, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        32'h00000000, 2'b00, 3};
        vecs[4]  = '{0, 6'h04, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        32'hCAFEF00D, 2'b00, 3};
        vecs[5]  = '{1, 6'h0C, 32'hDEADBEEF, 4'hF, 2, 0, 1, 0, 0, 2'b10, 0, 32'h0,        32'h00000000, 2'b10, 6};
        vecs[6]  = '{0, 6'h08, 32'h0,        4'h0, 0, 0, 0, 2, 0, 2'b11, 0, 32'h0,        32'h00000001, 2'b11, 5};
        vecs[7]  = '{1, 6'h04, 32'h11223344, 4'h3, 1, 1, 0, 0, 0, 2'b00, 0, 32'h0,        32'h00000000, 2'b00, 4};
        vecs[8]  = '{0, 6'h04, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        32'hCAFE3344, 2'b00, 3};
        vecs[9]  = '{1, 6'h2C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        32'h00000000, 2'b00, 3};
        vecs[10] = '{0, 6'h2C, 32'h0,        4'h0, 0, 0, 0, 0, 1, 2'b00, 0, 32'h0,        32'hFFFFFFFF, 2'b00, 4};
        vecs[11] = '{0, 6'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        32'hA5A5A5A5, 2'b00, 3};

        rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        s_bresp = 0; s_rresp = 0; hang_ar = 0; rov_en = 0; rov = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("reset_handshakes", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, tmo}), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_resp", 32'(rsp_resp), 32'd0);
        chk("reset_addr_data", {awaddr, araddr, wstrb, 16'h0} | wdata, 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        rst = 0;
        @(negedge clk);

        // Table-driven transactions, issued back to back
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // W accepted 3 cycles after AW: AW drops, W holds, BREADY waits for both
        aw_dly = 0; w_dly = 3; b_dly = 0; s_bresp = 0; rov_en = 0;
        p0 = pulses;
        issue(1, 6'h14, 32'h00000055, 4'hF);
        chk("skew_both_valid_at_plus1", 32'({awvalid, wvalid, bready}), 32'b110);
        chk("skew_awaddr", 32'(awaddr), 32'h14);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("skew_wait_c%0d", c), 32'({awvalid, wvalid, bready}), 32'b010);
            chk($sformatf("skew_wdata_c%0d", c), wdata, 32'h00000055);
        end
        @(negedge clk);
        chk("skew_bready_after_both", 32'({awvalid, wvalid, bready}), 32'b001);
        wait_rsp(n);
        chk("skew_rsp_latency", 32'(n), 32'd2);
        chk("skew_resp", 32'(rsp_resp), 32'd0);
        repeat (3) @(negedge clk);
        chk("skew_single_pulse", 32'(pulses - p0), 32'd1);

        // Reset while AWVALID is high, then a clean write/read
        aw_dly = 5; w_dly = 5;
        p0 = pulses;
        issue(1, 6'h18, 32'h0BADF00D, 4'hF);
        chk("midrst_awvalid_before", 32'(awvalid), 32'd1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_handshakes", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, tmo}), 32'd0);
        chk("midrst_addr_data", {awaddr, 26'h0} | wdata, 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        run_vec('{1, 6'h18, 32'h00000077, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 2'b00, 3}, 20);
        run_vec('{0, 6'h18, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h00000077, 2'b00, 3}, 21);

`ifdef MPS_AXI_MASTER_TIMEOUT_EN
        // ARREADY never arrives: watchdog fires 16 edges after the accept edge
        hang_ar = 1;
        issue(0, 6'h00, 32'h0, 4'h0);
        wait_rsp(n);
        chk("tmo_latency", 32'(n), 32'd16);
        chk("tmo_resp", 32'(rsp_resp), 32'b10);
        chk("tmo_flag", 32'(tmo), 32'd1);
        chk("tmo_arvalid_dropped", 32'({arvalid, rready}), 32'd0);
        @(negedge clk);
        chk("tmo_flag_cleared", 32'(tmo), 32'd0);
        hang_ar = 0;
        run_vec('{0, 6'h18, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h00000077, 2'b00, 3}, 30);
`endif

        repeat (2) @(negedge clk);
        chk("total_pulses", 32'(pulses), 32'(exp_pulses));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
